// File: rtl/ring_code_monitor_pkg.sv
// ring_pkg: shared types, constants and helpers for the ring-code monitor.
//   ring_mon_state_t : monitor FSM states (HUNT = 0 so reset clears it to zero)
//   ring_succ        : expected successor of a ring code for a given width/direction
//   ring_iw          : index width for a ring of a given width
//   ERR_CNT_W / ERR_CNT_MAX : error counter width and saturation value
package ring_pkg;

  localparam int unsigned ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  // Widest ring the successor helper supports.
  localparam int unsigned RING_MAX_W  = 64;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ring_mon_state_t;

  function automatic int unsigned ring_iw(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // dir = 0: rotate right, bit i takes bit i+1 and the top bit takes bit 0.
  // dir = 1: rotate left,  bit i takes bit i-1 and bit 0 takes the top bit.
  function automatic logic [RING_MAX_W-1:0] ring_succ(
    input logic [RING_MAX_W-1:0] code,
    input int unsigned           width,
    input logic                  dir
  );
    logic [RING_MAX_W-1:0] s;
    logic [5:0]            src;
    s = '0;
    for (int unsigned i = 0; i < RING_MAX_W; i++) begin
      if (i < width) begin
        if (!dir) src = 6'((i + 1) % width);
        else      src = 6'((i + width - 1) % width);
        s[i] = code[src];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/ring_code_monitor_if.sv
// ring_code_monitor_if: sample/result bundle of the ring-code monitor.
//   enable_i, ring_i, err_clr_i  : sample qualifier, code under test, error-count clear
//   index_o, index_valid_o       : decoded index of last legal sample, last sample one-hot
//   locked_o                     : monitor locked
//   code_err_o, seq_err_o        : one-cycle error pulses
//   err_count_o                  : saturating error count
// master drives the samples, slave is the monitor.
interface ring_code_monitor_if
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = 3
);
  localparam int unsigned IW = ring_iw(WIDTH);

  logic                 enable_i;
  logic [WIDTH-1:0]     ring_i;
  logic                 err_clr_i;
  logic [IW-1:0]        index_o;
  logic                 index_valid_o;
  logic                 locked_o;
  logic                 code_err_o;
  logic                 seq_err_o;
  logic [ERR_CNT_W-1:0] err_count_o;

  modport master (
    output enable_i, ring_i, err_clr_i,
    input  index_o, index_valid_o, locked_o, code_err_o, seq_err_o, err_count_o
  );

  modport slave (
    input  enable_i, ring_i, err_clr_i,
    output index_o, index_valid_o, locked_o, code_err_o, seq_err_o, err_count_o
  );

endinterface

// File: rtl/ring_onehot_enc.sv
// ring_onehot_enc: combinational one-hot check and index encoder.
//   code_i  : ring code
//   legal_o : exactly one bit of code_i is set
//   index_o : position of the set bit (meaningful only when legal_o = 1)
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter  int unsigned WIDTH = 3,
  localparam int unsigned IW    = ring_iw(WIDTH)
) (
  input  logic [WIDTH-1:0] code_i,
  output logic             legal_o,
  output logic [IW-1:0]    index_o
);

  always_comb begin
    int unsigned ones;
    ones    = 0;
    index_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (code_i[i]) begin
        ones    = ones + 1;
        index_o = index_o | IW'(i);
      end
    end
    legal_o = (ones == 1);
  end

endmodule

// File: rtl/ring_code_monitor.sv
// ring_code_monitor: checks that a sampled one-hot ring code is legal and steps
// to the correct successor, decodes it to an index, declares lock after
// LOCK_COUNT correct steps and counts errors (saturating).
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   mon      : sample inputs and registered results (see ring_code_monitor_if)
// Parameters: WIDTH ring width (>=2), LOCK_COUNT correct steps to lock (>=1),
// DIR 0 = rotate right, 1 = rotate left.
module ring_code_monitor
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned DIR        = 0
) (
  input  logic               clk,
  input  logic               rst,
  ring_code_monitor_if.slave mon
);

  localparam int unsigned IW = ring_iw(WIDTH);
  localparam int unsigned RW = $clog2(LOCK_COUNT + 1);

  ring_mon_state_t      state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [RW-1:0]        run_q, run_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 code_err_q, code_err_d;
  logic                 seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic                  legal;
  logic [IW-1:0]         enc_idx;
  logic [RING_MAX_W-1:0] succ_full;
  logic                  is_succ;

  ring_onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .code_i  (mon.ring_i),
    .legal_o (legal),
    .index_o (enc_idx)
  );

  assign succ_full = ring_succ(RING_MAX_W'(prev_q), WIDTH, (DIR != 0));
  assign is_succ   = (mon.ring_i == succ_full[WIDTH-1:0]);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    code_err_d = 1'b0;
    seq_err_d  = 1'b0;
    cnt_d      = cnt_q;

    if (mon.enable_i) begin
      valid_d = legal;
      if (legal) begin
        idx_d  = enc_idx;
        prev_d = mon.ring_i;
      end

      unique case (state_q)
        HUNT: begin
          if (legal) begin
            run_d   = '0;
            state_d = VERIFY;
          end else begin
            code_err_d = 1'b1;
          end
        end
        VERIFY: begin
          if (!legal) begin
            code_err_d = 1'b1;
            state_d    = HUNT;
          end else if (is_succ) begin
            run_d = run_q + RW'(1);
            if (run_q == RW'(LOCK_COUNT - 1)) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!legal) begin
            code_err_d = 1'b1;
            state_d    = HUNT;
          end else if (!is_succ) begin
            seq_err_d = 1'b1;
            run_d     = '0;
            state_d   = VERIFY;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear first so a same-edge clear and error leaves a count of one.
    if (mon.err_clr_i) cnt_d = '0;
    if ((code_err_d || seq_err_d) && (cnt_d != ERR_CNT_MAX)) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      prev_q     <= '0;
      run_q      <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      code_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      code_err_q <= code_err_d;
      seq_err_q  <= seq_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mon.index_o       = idx_q;
  assign mon.index_valid_o = valid_q;
  assign mon.locked_o      = (state_q == LOCKED);
  assign mon.code_err_o    = code_err_q;
  assign mon.seq_err_o     = seq_err_q;
  assign mon.err_count_o   = cnt_q;

endmodule

// File: tb/tb_ring_code_monitor.sv
// Bench for ring_code_monitor (WIDTH=3, LOCK_COUNT=2, DIR=0, 20 ns clock).
// Directed scenarios followed by random samples, all checked against a
// behavioural model that tracks the ring position as an integer index.
module tb_ring_code_monitor;

  localparam int W  = 3;
  localparam int LC = 2;

  logic clk = 1'b1;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  ring_code_monitor_if #(.WIDTH(W)) rif ();

  ring_code_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .DIR(0)) dut (
    .clk (clk),
    .rst (rst),
    .mon (rif)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: 0 = hunting, 1 = verifying, 2 = locked.
  int m_mode, m_run, m_prev, m_idx, m_valid, m_cerr, m_serr, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_run = 0; m_prev = 0; m_idx = 0;
    m_valid = 0; m_cerr = 0; m_serr = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input logic en, input logic [W-1:0] code, input logic clr);
    int pos;
    bit correct;
    m_cerr = 0;
    m_serr = 0;
    if (en) begin
      if ($countones(code) == 1) begin
        pos = 0;
        for (int i = 0; i < W; i++) if (code[i]) pos = i;
        // Rotating right moves the set bit one position down, wrapping at 0.
        correct = (pos == (m_prev + W - 1) % W);
        case (m_mode)
          0: begin m_mode = 1; m_run = 0; end
          1: begin
            if (correct) begin
              m_run++;
              if (m_run == LC) m_mode = 2;
            end else m_run = 0;
          end
          default: begin
            if (!correct) begin m_serr = 1; m_run = 0; m_mode = 1; end
          end
        endcase
        m_prev  = pos;
        m_idx   = pos;
        m_valid = 1;
      end else begin
        m_valid = 0;
        m_cerr  = 1;
        m_mode  = 0;
      end
    end
    if (clr) m_cnt = 0;
    if ((m_cerr || m_serr) && m_cnt < 255) m_cnt++;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".index"},  32'(rif.index_o),       32'(m_idx));
    chk({tag, ".valid"},  32'(rif.index_valid_o), 32'(m_valid));
    chk({tag, ".locked"}, 32'(rif.locked_o),      32'(m_mode == 2));
    chk({tag, ".cerr"},   32'(rif.code_err_o),    32'(m_cerr));
    chk({tag, ".serr"},   32'(rif.seq_err_o),     32'(m_serr));
    chk({tag, ".cnt"},    32'(rif.err_count_o),   32'(m_cnt));
  endtask

  task automatic step(input string tag, input logic en, input logic [W-1:0] code, input logic clr);
    @(negedge clk);
    rif.enable_i  = en;
    rif.ring_i    = code;
    rif.err_clr_i = clr;
    @(posedge clk);
    model_step(en, code, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] code;
    logic         en, clr;

    rif.enable_i  = 1'b0;
    rif.ring_i    = '0;
    rif.err_clr_i = 1'b0;
    model_reset();

    // Reset held for 50 ns, released on a falling edge.
    #49;
    check_all("reset");
    #1 rst = 1'b0;

    // Acquire lock.
    step("lk0", 1'b1, 3'b100, 1'b0); chk("lk0.idx2", 32'(rif.index_o), 32'd2);
    step("lk1", 1'b1, 3'b010, 1'b0); chk("lk1.idx1", 32'(rif.index_o), 32'd1);
    chk("lk1.notlocked", 32'(rif.locked_o), 32'd0);
    step("lk2", 1'b1, 3'b001, 1'b0); chk("lk2.idx0", 32'(rif.index_o), 32'd0);
    chk("lk2.locked", 32'(rif.locked_o), 32'd1);
    step("lk3", 1'b1, 3'b100, 1'b0); chk("lk3.idx2", 32'(rif.index_o), 32'd2);
    chk("lk3.cnt0", 32'(rif.err_count_o), 32'd0);

    // Illegal code 110 while locked.
    step("ill110", 1'b1, 3'b110, 1'b0);
    chk("ill110.cerr", 32'(rif.code_err_o), 32'd1);
    chk("ill110.cnt", 32'(rif.err_count_o), 32'd1);
    chk("ill110.hold_idx", 32'(rif.index_o), 32'd2);
    step("rl0", 1'b1, 3'b100, 1'b0);
    chk("rl0.pulse_end", 32'(rif.code_err_o), 32'd0);
    step("rl1", 1'b1, 3'b010, 1'b0);
    step("rl2", 1'b1, 3'b001, 1'b0);
    // All-zero while locked.
    step("ill000", 1'b1, 3'b000, 1'b0);
    chk("ill000.cerr", 32'(rif.code_err_o), 32'd1);
    chk("ill000.locked", 32'(rif.locked_o), 32'd0);
    chk("ill000.cnt", 32'(rif.err_count_o), 32'd2);
    step("rl3", 1'b1, 3'b100, 1'b0);
    step("rl4", 1'b1, 3'b010, 1'b0);
    step("rl5", 1'b1, 3'b001, 1'b0);
    step("rl6", 1'b1, 3'b100, 1'b0);

    // Skipped step while locked, then relock in two steps.
    step("skip", 1'b1, 3'b001, 1'b0);
    chk("skip.serr", 32'(rif.seq_err_o), 32'd1);
    chk("skip.cnt", 32'(rif.err_count_o), 32'd3);
    step("sk1", 1'b1, 3'b100, 1'b0);
    chk("sk1.notlocked", 32'(rif.locked_o), 32'd0);
    step("sk2", 1'b1, 3'b010, 1'b0);
    chk("sk2.locked", 32'(rif.locked_o), 32'd1);

    // Asynchronous reset between edges while locked.
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.locked", 32'(rif.locked_o), 32'd0);
    chk("arst.cnt",    32'(rif.err_count_o), 32'd0);
    check_all("arst");
    #2 rst = 1'b0;
    step("ar0", 1'b1, 3'b010, 1'b0);
    step("ar1", 1'b1, 3'b001, 1'b0);
    chk("ar1.notlocked", 32'(rif.locked_o), 32'd0);
    step("ar2", 1'b1, 3'b100, 1'b0);
    chk("ar2.locked", 32'(rif.locked_o), 32'd1);

    // Error counter saturation and clears.
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 3'b111, 1'b0);
    chk("sat.cnt255", 32'(rif.err_count_o), 32'd255);
    step("clr", 1'b1, 3'b100, 1'b1);
    chk("clr.cnt0", 32'(rif.err_count_o), 32'd0);
    step("clrerr", 1'b1, 3'b111, 1'b1);
    chk("clrerr.cnt1", 32'(rif.err_count_o), 32'd1);

    // Enable low: errors in the inputs are ignored.
    step("en0", 1'b1, 3'b100, 1'b0);
    step("en1", 1'b1, 3'b010, 1'b0);
    step("en2", 1'b1, 3'b001, 1'b0);
    step("dis_ill", 1'b0, 3'b110, 1'b0);
    chk("dis_ill.locked", 32'(rif.locked_o), 32'd1);
    chk("dis_ill.idx", 32'(rif.index_o), 32'd0);
    step("dis_seq", 1'b0, 3'b010, 1'b0);
    chk("dis_seq.serr", 32'(rif.seq_err_o), 32'd0);
    chk("dis_seq.idx", 32'(rif.index_o), 32'd0);
    step("en3", 1'b1, 3'b100, 1'b0);
    chk("en3.locked", 32'(rif.locked_o), 32'd1);

    // Random samples, biased toward correct successors.
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 6) code = W'(1 << ((m_prev + W - 1) % W));
      else                          code = W'($urandom_range(0, 7));
      step("rnd", en, code, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
